// File: rtl/alu_serial_responder.sv
// alu_serial_responder: bit-serial ALU behind req/rsp handshakes, BPC bits per cycle; ALU_RSP_COUNT_EN adds rsp_count
module alu_serial_responder #(
   parameter int WIDTH = 32,
   parameter int BPC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_zero,
   output logic             rsp_overflow,
   output logic             rsp_cout,
   output logic             rsp_less
`ifdef ALU_RSP_COUNT_EN
   ,
   output logic [15:0]      rsp_count
`endif
);
   localparam int N = WIDTH / BPC;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, res, res_nx, out_nx;
   logic [2:0] op_r;
   logic [IW-1:0] idx;
   logic carry, is_add, is_sub, is_slt, is_arith, last, c_msb, ovf, less;
   logic [BPC-1:0] a_sl, b_sl, bits;
   logic [BPC:0] sum;
   always_comb begin
      is_add = op_r == 3'b010;
      is_sub = op_r == 3'b110;
      is_slt = op_r == 3'b111;
      is_arith = is_add || is_sub || is_slt;
      last = idx == IW'(N - 1);
      a_sl = a_r[BPC-1:0];
      b_sl = b_r[BPC-1:0] ^ {BPC{is_sub || is_slt}};
      sum = {1'b0, a_sl} + {1'b0, b_sl} + (BPC + 1)'(carry);
      // carry into the top bit of the slice, recovered from its sum bit
      c_msb = sum[BPC-1] ^ a_sl[BPC-1] ^ b_sl[BPC-1];
      ovf = c_msb ^ sum[BPC];
      less = sum[BPC-1] ^ ovf;
      bits = op_r == 3'b000 ? a_sl & b_sl :
             op_r == 3'b001 ? a_sl | b_sl :
             is_arith ? sum[BPC-1:0] : '0;
      res_nx = (res >> BPC) | (WIDTH'(bits) << (WIDTH - BPC));
      out_nx = is_slt ? WIDTH'(less) : res_nx;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = req_valid ? CALC : IDLE;
         CALC: state_nx = last ? DONE : CALC;
         DONE: state_nx = rsp_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      req_ready = state == IDLE && !rst;
      rsp_valid = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r <= '0;
         b_r <= '0;
         op_r <= '0;
         idx <= '0;
         carry <= 1'b0;
         res <= '0;
         rsp_out <= '0;
         rsp_zero <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_cout <= 1'b0;
         rsp_less <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            a_r <= req_a;
            b_r <= req_b;
            op_r <= req_op;
            idx <= '0;
            carry <= req_op == 3'b110 || req_op == 3'b111;
            res <= '0;
         end
         if (state == CALC) begin
            a_r <= a_r >> BPC;
            b_r <= b_r >> BPC;
            res <= res_nx;
            carry <= sum[BPC];
            idx <= idx + 1'b1;
            if (last) begin
               rsp_out <= out_nx;
               rsp_zero <= out_nx == '0;
               rsp_overflow <= (is_add || is_sub) && ovf;
               rsp_cout <= is_arith && sum[BPC];
               rsp_less <= (is_sub || is_slt) && less;
            end
         end
      end
   end
`ifdef ALU_RSP_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) rsp_count <= '0;
      else if (state == DONE && rsp_ready) rsp_count <= rsp_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_alu_serial_responder.sv
// tb_alu_serial_responder: directed table, corner sequences and random ops against an arithmetic reference model
module tb_alu_serial_responder;
   typedef struct packed {logic [31:0] out; logic z, o, c, l;} res_t;
   typedef struct packed {logic [31:0] a, b; logic [2:0] op; int hold; res_t exp;} vec_t;
   logic clk = 1'b0, rst, req_valid, rsp_ready, req_ready, rsp_valid;
   logic [31:0] req_a, req_b, rsp_out;
   logic [2:0] req_op;
   logic rsp_zero, rsp_overflow, rsp_cout, rsp_less;
`ifdef ALU_RSP_COUNT_EN
   logic [15:0] rsp_count;
`endif
   int tests = 0, fails = 0;
   alu_serial_responder dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
      .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout), .rsp_less(rsp_less)
`ifdef ALU_RSP_COUNT_EN
      , .rsp_count(rsp_count)
`endif
   );
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask
   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got timeout required handshake", name);
   endtask
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      res_t r;
      logic [32:0] s;
      logic [31:0] d;
      logic lt, vs;
      r = '0;
      d = a - b;
      lt = $signed(a) < $signed(b);
      vs = (a[31] != b[31]) && (d[31] != a[31]);
      case (op)
         3'b000: r.out = a & b;
         3'b001: r.out = a | b;
         3'b010: begin
            s = {1'b0, a} + {1'b0, b};
            r.out = s[31:0];
            r.c = s[32];
            r.o = (a[31] == b[31]) && (s[31] != a[31]);
         end
         3'b110: begin
            r.out = d;
            r.c = a >= b;
            r.o = vs;
            r.l = lt;
         end
         3'b111: begin
            r.out = {31'b0, lt};
            r.c = a >= b;
            r.l = lt;
         end
         default: r.out = '0;
      endcase
      r.z = r.out == 0;
      return r;
   endfunction
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input int hold, output res_t got, output int lat);
      int n;
      got = '0;
      lat = -1;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         timeout("req_ready_wait");
         return;
      end
      req_valid = 1'b1;
      req_a = a;
      req_b = b;
      req_op = op;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_a = $urandom;
      req_b = $urandom;
      req_op = 3'($urandom);
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!rsp_valid) begin
         timeout("rsp_valid_wait");
         return;
      end
      got = {rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_less};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_a = $urandom;
         req_op = 3'b010;
         chk($sformatf("hold_stable%0d", i),
             {rsp_valid, req_ready, rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_less}, {2'b10, got});
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("post_handshake", {rsp_valid, req_ready}, 2'b01);
   endtask
   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input int hold, input res_t exp);
      res_t got;
      int lat;
      do_op(a, b, op, hold, got, lat);
      chk({tag, "_latency"}, lat, 32);
      chk({tag, "_result"}, got, exp);
   endtask
   vec_t vt[11];
   logic [2:0] ops[8];
   logic [31:0] edge_v[4];
   initial begin
      vt[0]  = '{32'h00007F55, 32'h00000DD9, 3'b010, 0, '{32'h00008D2E, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[1]  = '{32'h00007F55, 32'h00000DD9, 3'b000, 0, '{32'h00000D51, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[2]  = '{32'h00007F55, 32'h00000DD9, 3'b111, 0, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
      vt[3]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 0, '{32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1}};
      vt[4]  = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 0, '{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0}};
      vt[5]  = '{32'h00000005, 32'h00000005, 3'b110, 10, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
      vt[6]  = '{32'hF0F00000, 32'h0F0F00FF, 3'b001, 0, '{32'hFFFF00FF, 1'b0, 1'b0, 1'b0, 1'b0}};
      vt[7]  = '{32'h00001234, 32'h00005678, 3'b011, 0, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0}};
      vt[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 2, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0}};
      vt[9]  = '{32'hFFFFFFFF, 32'h00000001, 3'b010, 0, '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}};
      vt[10] = '{32'h80000000, 32'h00000001, 3'b110, 1, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b1}};
      ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
      edge_v = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      rst = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      req_a = '0;
      req_b = '0;
      req_op = '0;
      @(negedge clk);
      chk("ready_in_rst", req_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_state", {req_ready, rsp_valid, rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_less},
          {2'b10, 36'b0});
      for (int i = 0; i < 11; i++)
         run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].op, vt[i].hold, vt[i].exp);
      // abandon an ADD part way through CALC
      begin
         int n;
         @(negedge clk);
         req_valid = 1'b1;
         req_a = 32'd1;
         req_b = 32'd1;
         req_op = 3'b010;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         repeat (15) @(posedge clk);
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1;
         chk("abort_cleared", {rsp_valid, req_ready, rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_less}, 38'b0);
         @(negedge clk);
         rst = 1'b0;
         n = 0;
         repeat (40) begin
            @(negedge clk);
            if (rsp_valid) n++;
         end
         chk("abort_no_response", n, 0);
         run_check("after_abort", 32'd1, 32'd2, 3'b010, 0, '{32'd3, 1'b0, 1'b0, 1'b0, 1'b0});
      end
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         logic [2:0] op;
         a = $urandom_range(0, 3) == 0 ? edge_v[$urandom_range(0, 3)] : $urandom;
         b = $urandom_range(0, 3) == 0 ? edge_v[$urandom_range(0, 3)] : $urandom;
         if ($urandom_range(0, 7) == 0) b = a;
         op = ops[$urandom_range(0, 7)];
         run_check($sformatf("rand%0d_op%0b", i, op), a, b, op, $urandom_range(0, 3), model(a, b, op));
      end
`ifdef ALU_RSP_COUNT_EN
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("count_reset", rsp_count, 16'h0000);
      for (int i = 0; i < 3; i++)
         run_check($sformatf("count_op%0d", i), 32'd10, 32'(i), 3'b110, 0, model(32'd10, 32'(i), 3'b110));
      chk("count_three", rsp_count, 16'h0003);
      @(negedge clk);
      force dut.rsp_count = 16'hFFFF;
      #1;
      release dut.rsp_count;
      run_check("count_wrap_op", 32'd4, 32'd4, 3'b000, 0, model(32'd4, 32'd4, 3'b000));
      chk("count_wrap", rsp_count, 16'h0000);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
